// File: rtl/axi_sft_tmr_crossbar_wcmd.sv
// TMR write-command queue: votes three replicated command streams into a FIFO and steers W bursts.
// Optional macro TMR_ERR_CNT_EN adds the saturating tmr_err_cnt mismatch counter port.
module axi_sft_tmr_crossbar_wcmd #(
  parameter int M_COUNT    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int FIFO_DEPTH = 4,
  localparam int SEL_W     = (M_COUNT > 1) ? $clog2(M_COUNT) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SEL_W-1:0]      s_wc_select_tmr0,
  input  logic [SEL_W-1:0]      s_wc_select_tmr1,
  input  logic [SEL_W-1:0]      s_wc_select_tmr2,
  input  logic                  s_wc_decerr_tmr0,
  input  logic                  s_wc_decerr_tmr1,
  input  logic                  s_wc_decerr_tmr2,
  input  logic                  s_wc_valid_tmr0,
  input  logic                  s_wc_valid_tmr1,
  input  logic                  s_wc_valid_tmr2,
  output logic                  s_wc_ready_tmr0,
  output logic                  s_wc_ready_tmr1,
  output logic                  s_wc_ready_tmr2,
  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
  input  logic                  s_axi_wlast,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [STRB_WIDTH-1:0] m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic [M_COUNT-1:0]    m_axi_wvalid,
  input  logic [M_COUNT-1:0]    m_axi_wready,
  output logic                  tmr_mismatch
`ifdef TMR_ERR_CNT_EN
  ,
  output logic [7:0]            tmr_err_cnt
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [SEL_W-1:0] voted_sel;
  logic             voted_decerr;
  logic             voted_valid;
  logic             any_valid;
  logic             sel_diff;
  logic             decerr_diff;
  logic             valid_diff;
  logic             mismatch_now;

  logic [SEL_W-1:0] fifo_sel    [FIFO_DEPTH];
  logic             fifo_decerr [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  logic [SEL_W-1:0]   head_sel;
  logic               head_decerr;
  logic [M_COUNT-1:0] head_onehot;

  // Bitwise 2-of-3 majority on every command field.
  assign voted_sel    = (s_wc_select_tmr0 & s_wc_select_tmr1) |
                        (s_wc_select_tmr0 & s_wc_select_tmr2) |
                        (s_wc_select_tmr1 & s_wc_select_tmr2);
  assign voted_decerr = (s_wc_decerr_tmr0 & s_wc_decerr_tmr1) |
                        (s_wc_decerr_tmr0 & s_wc_decerr_tmr2) |
                        (s_wc_decerr_tmr1 & s_wc_decerr_tmr2);
  assign voted_valid  = (s_wc_valid_tmr0 & s_wc_valid_tmr1) |
                        (s_wc_valid_tmr0 & s_wc_valid_tmr2) |
                        (s_wc_valid_tmr1 & s_wc_valid_tmr2);

  assign any_valid    = s_wc_valid_tmr0 | s_wc_valid_tmr1 | s_wc_valid_tmr2;
  assign sel_diff     = |((s_wc_select_tmr0 ^ voted_sel) |
                          (s_wc_select_tmr1 ^ voted_sel) |
                          (s_wc_select_tmr2 ^ voted_sel));
  assign decerr_diff  = (s_wc_decerr_tmr0 ^ voted_decerr) |
                        (s_wc_decerr_tmr1 ^ voted_decerr) |
                        (s_wc_decerr_tmr2 ^ voted_decerr);
  assign valid_diff   = (s_wc_valid_tmr0 ^ voted_valid) |
                        (s_wc_valid_tmr1 ^ voted_valid) |
                        (s_wc_valid_tmr2 ^ voted_valid);
  assign mismatch_now = any_valid & (sel_diff | decerr_diff | valid_diff);

  assign full  = (count == CNT_W'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign push  = voted_valid & ~full;
  assign pop   = s_axi_wvalid & s_axi_wready & s_axi_wlast;

  // Ready depends only on registered occupancy, never on the incoming valid.
  assign s_wc_ready_tmr0 = ~full;
  assign s_wc_ready_tmr1 = ~full;
  assign s_wc_ready_tmr2 = ~full;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_sel[wr_ptr]    <= voted_sel;
      fifo_decerr[wr_ptr] <= voted_decerr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign head_sel    = fifo_sel[rd_ptr];
  assign head_decerr = fifo_decerr[rd_ptr];

  always_comb begin
    head_onehot = '0;
    for (int i = 0; i < M_COUNT; i++) begin
      head_onehot[i] = (head_sel == SEL_W'(i));
    end
  end

  // Decode-error bursts are accepted and dropped so the slave never hangs.
  always_comb begin
    m_axi_wvalid = '0;
    s_axi_wready = 1'b0;
    if (!empty) begin
      if (head_decerr) begin
        s_axi_wready = 1'b1;
      end else begin
        m_axi_wvalid = head_onehot & {M_COUNT{s_axi_wvalid}};
        s_axi_wready = |(head_onehot & m_axi_wready);
      end
    end
  end

  assign m_axi_wdata = s_axi_wdata;
  assign m_axi_wstrb = s_axi_wstrb;
  assign m_axi_wlast = s_axi_wlast;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmr_mismatch <= 1'b0;
    end else begin
      tmr_mismatch <= mismatch_now;
    end
  end

`ifdef TMR_ERR_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmr_err_cnt <= 8'h00;
    end else if (tmr_mismatch && (tmr_err_cnt != 8'hFF)) begin
      tmr_err_cnt <= tmr_err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_axi_sft_tmr_crossbar_wcmd.sv
// Directed bench for axi_sft_tmr_crossbar_wcmd; counter checks follow TMR_ERR_CNT_EN.
module tb_axi_sft_tmr_crossbar_wcmd;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  sel0, sel1, sel2;
  logic        dec0, dec1, dec2;
  logic        v0, v1, v2;
  logic        r0, r1, r2;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_wlast;
  logic [3:0]  m_wvalid;
  logic [3:0]  m_wready;
  logic        mismatch;
`ifdef TMR_ERR_CNT_EN
  logic [7:0]  err_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  axi_sft_tmr_crossbar_wcmd #(
    .M_COUNT(4), .DATA_WIDTH(32), .STRB_WIDTH(4), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst),
    .s_wc_select_tmr0(sel0), .s_wc_select_tmr1(sel1), .s_wc_select_tmr2(sel2),
    .s_wc_decerr_tmr0(dec0), .s_wc_decerr_tmr1(dec1), .s_wc_decerr_tmr2(dec2),
    .s_wc_valid_tmr0(v0), .s_wc_valid_tmr1(v1), .s_wc_valid_tmr2(v2),
    .s_wc_ready_tmr0(r0), .s_wc_ready_tmr1(r1), .s_wc_ready_tmr2(r2),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .m_axi_wdata(m_wdata), .m_axi_wstrb(m_wstrb), .m_axi_wlast(m_wlast),
    .m_axi_wvalid(m_wvalid), .m_axi_wready(m_wready),
    .tmr_mismatch(mismatch)
`ifdef TMR_ERR_CNT_EN
    , .tmr_err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c,
                         input logic d, input logic v);
    sel0 = a; sel1 = b; sel2 = c;
    dec0 = d; dec1 = d; dec2 = d;
    v0 = v; v1 = v; v2 = v;
  endtask

  task automatic push(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c,
                      input logic d);
    set_cmd(a, b, c, d, 1'b1);
    tick();
    set_cmd(2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    set_cmd(2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
    wdata = 32'h0; wstrb = 4'h0; wlast = 1'b0; wvalid = 1'b1; m_wready = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wready", 32'(wready), 32'h0);
    chk("rst_mwvalid", 32'(m_wvalid), 32'h0);
    chk("rst_mismatch", 32'(mismatch), 32'h0);
`ifdef TMR_ERR_CNT_EN
    chk("rst_errcnt", 32'(err_cnt), 32'h0);
`endif
    rst = 1'b0;
    #1;
    chk("rst_cmd_ready", 32'({r0, r1, r2}), 32'h7);

    // 1: unanimous select=2, 4-beat burst; no bypass while empty
    set_cmd(2'd2, 2'd2, 2'd2, 1'b0, 1'b1);
    wvalid = 1'b1; wlast = 1'b0; m_wready = 4'b0100;
    #1;
    chk("t1_nobypass_wready", 32'(wready), 32'h0);
    chk("t1_nobypass_mwvalid", 32'(m_wvalid), 32'h0);
    tick();
    set_cmd(2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
    for (int b = 0; b < 4; b++) begin
      wlast = (b == 3);
      wdata = 32'hA000_0000 + 32'(b);
      wstrb = 4'hF ^ 4'(b);
      #1;
      chk("t1_mwvalid", 32'(m_wvalid), 32'h4);
      chk("t1_wready", 32'(wready), 32'h1);
      chk("t1_wdata", m_wdata, 32'hA000_0000 + 32'(b));
      chk("t1_wstrb", 32'(m_wstrb), 32'(4'hF ^ 4'(b)));
      chk("t1_wlast", 32'(m_wlast), (b == 3) ? 32'h1 : 32'h0);
      tick();
    end
    chk("t1_empty_wready", 32'(wready), 32'h0);
    chk("t1_empty_mwvalid", 32'(m_wvalid), 32'h0);
    chk("t1_no_mismatch", 32'(mismatch), 32'h0);

    // 2: replica 1 disagrees on select, majority routes to master 1
    wvalid = 1'b0; wlast = 1'b0;
    push(2'd1, 2'd3, 2'd1, 1'b0);
    chk("t2_mismatch_pulse", 32'(mismatch), 32'h1);
    wvalid = 1'b1; wlast = 1'b1; m_wready = 4'b0010;
    #1;
    chk("t2_mwvalid", 32'(m_wvalid), 32'h2);
    chk("t2_wready", 32'(wready), 32'h1);
    m_wready = 4'b0000;
    #1;
    chk("t2_backpressure", 32'(wready), 32'h0);
    m_wready = 4'b0010;
    tick();
    chk("t2_mismatch_clear", 32'(mismatch), 32'h0);
    chk("t2_empty", 32'(wready), 32'h0);
`ifdef TMR_ERR_CNT_EN
    chk("t2_errcnt", 32'(err_cnt), 32'h1);
`endif

    // 3: decerr command sinks a 3-beat burst
    wvalid = 1'b0; wlast = 1'b0;
    push(2'd0, 2'd0, 2'd0, 1'b1);
    m_wready = 4'b0000; wvalid = 1'b1;
    for (int b = 0; b < 3; b++) begin
      wlast = (b == 2);
      #1;
      chk("t3_wready", 32'(wready), 32'h1);
      chk("t3_mwvalid", 32'(m_wvalid), 32'h0);
      tick();
    end
    chk("t3_empty", 32'(wready), 32'h0);

    // 4: fill, blocked push, pop-to-ready, push+pop, drain in order
    wvalid = 1'b0; wlast = 1'b0; m_wready = 4'b1111;
    push(2'd0, 2'd0, 2'd0, 1'b0);
    push(2'd1, 2'd1, 2'd1, 1'b0);
    push(2'd2, 2'd2, 2'd2, 1'b0);
    push(2'd3, 2'd3, 2'd3, 1'b0);
    chk("t4_full", 32'({r0, r1, r2}), 32'h0);
    set_cmd(2'd0, 2'd0, 2'd0, 1'b1, 1'b1);
    tick();
    set_cmd(2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
    wvalid = 1'b1; wlast = 1'b1;
    #1;
    chk("t4_head0", 32'(m_wvalid), 32'h1);
    tick();
    chk("t4_ready_after_pop", 32'({r0, r1, r2}), 32'h7);
    set_cmd(2'd0, 2'd0, 2'd0, 1'b0, 1'b1);
    #1;
    chk("t4_head1", 32'(m_wvalid), 32'h2);
    tick();
    wvalid = 1'b0;
    set_cmd(2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
    #1;
    chk("t4_pushpop_count", 32'({r0, r1, r2}), 32'h7);
    push(2'd0, 2'd0, 2'd0, 1'b1);
    chk("t4_full_again", 32'({r0, r1, r2}), 32'h0);
    wvalid = 1'b1; wlast = 1'b1;
    #1;
    chk("t4_drain_sel2", 32'(m_wvalid), 32'h4);
    tick();
    chk("t4_drain_sel3", 32'(m_wvalid), 32'h8);
    tick();
    chk("t4_drain_pushpop_entry", 32'(m_wvalid), 32'h1);
    tick();
    chk("t4_drain_decerr_mwvalid", 32'(m_wvalid), 32'h0);
    chk("t4_drain_decerr_wready", 32'(wready), 32'h1);
    tick();
    chk("t4_empty", 32'(wready), 32'h0);

    // 5: reset mid-burst with a second command queued
    wvalid = 1'b0; wlast = 1'b0;
    push(2'd1, 2'd1, 2'd1, 1'b0);
    push(2'd2, 2'd2, 2'd2, 1'b0);
    wvalid = 1'b1; wlast = 1'b0;
    for (int b = 0; b < 2; b++) begin
      #1;
      chk("t5_beat_mwvalid", 32'(m_wvalid), 32'h2);
      tick();
    end
    #2;
    rst = 1'b1;
    #1;
    chk("t5_rst_wready", 32'(wready), 32'h0);
    chk("t5_rst_mwvalid", 32'(m_wvalid), 32'h0);
    tick();
    rst = 1'b0;
    #1;
    chk("t5_cmd_ready", 32'({r0, r1, r2}), 32'h7);
    chk("t5_stall", 32'(wready), 32'h0);
    tick();
    chk("t5_stall2", 32'(wready), 32'h0);
    push(2'd3, 2'd3, 2'd3, 1'b0);
    chk("t5_new_route", 32'(m_wvalid), 32'h8);
    chk("t5_new_wready", 32'(wready), 32'h1);
    tick();
    wlast = 1'b1;
    #1;
    chk("t5_last_route", 32'(m_wvalid), 32'h8);
    tick();
    chk("t5_empty", 32'(wready), 32'h0);

    // 6: 300 single-replica valid faults, then a select fault
    wvalid = 1'b0; wlast = 1'b0;
    for (int i = 0; i < 300; i++) begin
      set_cmd(2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
      v0 = (i % 3 == 0); v1 = (i % 3 == 1); v2 = (i % 3 == 2);
      tick();
      if (i == 5) chk("t6_mismatch", 32'(mismatch), 32'h1);
    end
    set_cmd(2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
    tick();
    tick();
`ifdef TMR_ERR_CNT_EN
    chk("t6_errcnt_sat", 32'(err_cnt), 32'hFF);
`endif
    chk("t6_no_push", 32'({r0, r1, r2}), 32'h7);
    wvalid = 1'b1; wlast = 1'b1; m_wready = 4'b0100;
    #1;
    chk("t6_still_empty", 32'(wready), 32'h0);
    push(2'd2, 2'd2, 2'd0, 1'b0);
    chk("t6_route", 32'(m_wvalid), 32'h4);
    chk("t6_wready", 32'(wready), 32'h1);
    tick();
    chk("t6_empty", 32'(wready), 32'h0);
`ifdef TMR_ERR_CNT_EN
    tick();
    chk("t6_errcnt_hold", 32'(err_cnt), 32'hFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
